// File: rtl/mem_pkg.sv
// Shared encodings for the memory access master: access sizes, abort codes
// and the transaction FSM states.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_BAD  = 2'd3;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_SIZE     = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_e;

  // Request screening done in IDLE: illegal size beats misalignment.
  function automatic logic [1:0] check_req(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    logic [1:0] code;
    code = ERR_NONE;
    if (size == SZ_BAD)
      code = ERR_SIZE;
    else if ((size == SZ_HALF && addr_lo[0]) ||
             (size == SZ_WORD && addr_lo != 2'b00))
      code = ERR_MISALIGN;
    return code;
  endfunction

endpackage

// File: rtl/mem_access_master_load_extend.sv
// Combinational load extension: right-justified responder data is zero- or
// sign-filled for byte/halfword loads; words pass through.
module load_extend
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size_i,
  input  logic              sign_ext_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (size_i)
      SZ_BYTE: data_o = {{(DATA_W-8){sign_ext_i & data_i[7]}}, data_i[7:0]};
      SZ_HALF: data_o = {{(DATA_W-16){sign_ext_i & data_i[15]}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_access_master.sv
// CPU-side initiator for the byte/halfword/word RAM responder: screens the
// request, drives a stable bus through SETUP/WAIT and returns load data.
module mem_access_master
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic              done_err,
  output logic [DATA_W-1:0] rdata,
  output logic              mfa,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_mode,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              moc
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              moc_q;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        mem_mode_q, mem_mode_d;
  logic              sext_q, sext_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] ext_data;
  logic [1:0]        req_code;
  logic              moc_rise;

  load_extend #(.DATA_W(DATA_W)) u_ext (
    .size_i     (mem_mode_q),
    .sign_ext_i (sext_q),
    .data_i     (mem_rdata),
    .data_o     (ext_data)
  );

  assign req_code = check_req(size, addr[1:0]);
  // Completion is edge-qualified so a moc left high from the previous
  // transaction cannot complete the next one.
  assign moc_rise = moc & ~moc_q;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mode_d  = mem_mode_q;
    sext_d      = sext_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (req_code != ERR_NONE) begin
            err_d   = req_code;
            state_d = ST_ABORT;
          end else begin
            mem_rw_d    = rw;
            mem_addr_d  = addr;
            mem_wdata_d = wdata;
            mem_mode_d  = size;
            sext_d      = sign_ext;
            state_d     = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (moc_rise) begin
          if (mem_rw_q)
            rdata_d = ext_data;
          state_d = ST_DONE;
        end else if (timer_q == TLAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_ABORT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      moc_q       <= 1'b0;
      mem_rw_q    <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mode_q  <= '0;
      sext_q      <= 1'b0;
      err_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      moc_q       <= moc;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mode_q  <= mem_mode_d;
      sext_q      <= sext_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign busy      = (state_q == ST_SETUP) || (state_q == ST_WAIT);
  assign mfa       = (state_q == ST_WAIT);
  assign done      = (state_q == ST_DONE);
  assign done_err  = (state_q == ST_ABORT);
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_mode  = mem_mode_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Scoreboard bench for mem_access_master with a programmable moc responder.
module tb_mem_access_master;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset, req, rw, sign_ext;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, mem_rdata;
  logic          moc;
  logic          busy, done, done_err, mfa, mem_rw;
  logic [1:0]    err, mem_mode;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  typedef struct {
    logic          is_err;
    logic [1:0]    err;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] last_rd;
  int            n_vec = 0;
  int            n_bad = 0;

  logic moc_en    = 1'b0;
  logic moc_force = 1'b0;
  int   moc_delay = 0;
  int   wcnt      = 0;
  int   cyc       = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    wcnt <= mfa ? wcnt + 1 : 0;
    cyc  <= cyc + 1;
  end

  assign moc = moc_force | (moc_en & mfa & (wcnt == moc_delay));

  mem_access_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .err(err), .done_err(done_err), .rdata(rdata), .mfa(mfa),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mode(mem_mode), .mem_rdata(mem_rdata), .moc(moc)
  );

  function automatic logic [DW-1:0] model_ext(input logic [1:0] sz,
                                              input logic se,
                                              input logic [DW-1:0] d);
    logic [DW-1:0] r;
    if (sz == 2'd0)      r = (se && d[7])  ? {24'hFFFFFF, d[7:0]}  : {24'h0, d[7:0]};
    else if (sz == 2'd1) r = (se && d[15]) ? {16'hFFFF, d[15:0]}   : {16'h0, d[15:0]};
    else                 r = d;
    return r;
  endfunction

  task automatic predict(input logic r, input logic [1:0] sz, input logic se,
                         input logic [AW-1:0] a, input logic tmo);
    exp_t e;
    e.is_err = 1'b1;
    e.rd     = last_rd;
    if (sz == 2'd3)                                          e.err = 2'd3;
    else if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)) e.err = 2'd1;
    else if (tmo)                                            e.err = 2'd2;
    else begin
      e.is_err = 1'b0;
      e.err    = 2'd0;
      if (r) last_rd = model_ext(sz, se, mem_rdata);
      e.rd = last_rd;
    end
    sb.push_back(e);
  endtask

  // Drives one request for a single edge; returns on the following negedge.
  task automatic issue(input logic r, input logic [1:0] sz, input logic se,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic tmo);
    @(negedge clk);
    predict(r, sz, se, a, tmo);
    req = 1'b1; rw = r; size = sz; sign_ext = se; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_txn(input int budget, output int lat, output int wcyc,
                          output bit mfa_seen, output int done_cyc);
    int c;
    bit got;
    exp_t e;
    c = 1; got = 0; wcyc = 0; mfa_seen = 0;
    while (!got && c <= budget) begin
      if (mfa) begin wcyc++; mfa_seen = 1; end
      if (done || done_err) got = 1;
      else begin @(negedge clk); c++; end
    end
    lat = c;
    done_cyc = cyc;
    n_vec++;
    if (!got) begin
      n_bad++;
      $display("FAIL completion: no done/done_err within %0d cycles", budget);
    end else if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: completion with empty queue");
    end else begin
      e = sb.pop_front();
      if (done_err !== e.is_err || done !== !e.is_err) begin
        n_bad++;
        $display("FAIL kind: done=%b done_err=%b, expected done_err=%b", done, done_err, e.is_err);
      end
      n_vec++;
      if (rdata !== e.rd) begin
        n_bad++;
        $display("FAIL rdata: got %h expected %h", rdata, e.rd);
      end
      if (e.is_err) begin
        n_vec++;
        if (err !== e.err) begin
          n_bad++;
          $display("FAIL err_code: got %0d expected %0d", err, e.err);
        end
      end
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || done_err !== 1'b0 || mfa !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL pulse_len: done=%b done_err=%b mfa=%b busy=%b, expected all 0",
               done, done_err, mfa, busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 1'b0; rw = 1'b0; size = 2'd0; sign_ext = 1'b0;
    addr = '0; wdata = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done, done_err, err, rdata, mfa, mem_rw, mem_addr, mem_wdata, mem_mode} !==
        {1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 9'h0, 32'h0, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b done=%b derr=%b err=%0d rdata=%h mfa=%b rw=%b addr=%h wdata=%h mode=%0d",
               busy, done, done_err, err, rdata, mfa, mem_rw, mem_addr, mem_wdata, mem_mode);
    end
    reset = 1'b0;
    last_rd = '0;
  endtask

  task automatic test_word_store;
    int lat, wc, dc;
    bit ms;
    moc_en = 1'b1; moc_delay = 3;
    issue(1'b0, 2'd2, 1'b0, 9'h010, 32'hDEADBEEF, 1'b0);
    n_vec++;
    if (mfa !== 1'b0 || busy !== 1'b1 || mem_rw !== 1'b0 || mem_mode !== 2'd2 ||
        mem_addr !== 9'h010 || mem_wdata !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL store_setup: mfa=%b busy=%b rw=%b mode=%0d addr=%h wdata=%h",
               mfa, busy, mem_rw, mem_mode, mem_addr, mem_wdata);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (mfa !== 1'b1 || busy !== 1'b1 || mem_rw !== 1'b0 || mem_mode !== 2'd2 ||
          mem_addr !== 9'h010 || mem_wdata !== 32'hDEADBEEF || done !== 1'b0) begin
        n_bad++;
        $display("FAIL store_wait%0d: mfa=%b rw=%b mode=%0d addr=%h wdata=%h done=%b",
                 i, mfa, mem_rw, mem_mode, mem_addr, mem_wdata, done);
      end
    end
    wait_txn(4, lat, wc, ms, dc);
  endtask

  task automatic test_loads;
    int lat, wc, dc;
    bit ms;
    moc_en = 1'b1; moc_delay = 0;
    mem_rdata = 32'h00000080;
    issue(1'b1, 2'd0, 1'b1, 9'h013, '0, 1'b0);
    wait_txn(10, lat, wc, ms, dc);
    n_vec++;
    if (lat !== 3) begin
      n_bad++;
      $display("FAIL min_latency: got %0d edges expected 3", lat);
    end
    issue(1'b1, 2'd0, 1'b0, 9'h013, '0, 1'b0);
    wait_txn(10, lat, wc, ms, dc);
    mem_rdata = 32'h00008001;
    issue(1'b1, 2'd1, 1'b1, 9'h002, '0, 1'b0);
    wait_txn(10, lat, wc, ms, dc);
    mem_rdata = 32'h123456F0;
    issue(1'b1, 2'd0, 1'b1, 9'h005, '0, 1'b0);
    wait_txn(10, lat, wc, ms, dc);
    mem_rdata = 32'h87654321;
    issue(1'b1, 2'd1, 1'b0, 9'h006, '0, 1'b0);
    wait_txn(10, lat, wc, ms, dc);
    issue(1'b1, 2'd2, 1'b1, 9'h008, '0, 1'b0);
    wait_txn(10, lat, wc, ms, dc);
  endtask

  task automatic test_request_errors;
    int lat, wc, dc;
    bit ms;
    mem_rdata = 32'h00008001;
    issue(1'b1, 2'd1, 1'b1, 9'h003, '0, 1'b0);
    wait_txn(10, lat, wc, ms, dc);
    n_vec++;
    if (ms !== 1'b0 || lat !== 1) begin
      n_bad++;
      $display("FAIL misalign_half: mfa_seen=%b lat=%0d expected 0/1", ms, lat);
    end
    issue(1'b0, 2'd2, 1'b0, 9'h012, 32'h1, 1'b0);
    wait_txn(10, lat, wc, ms, dc);
    issue(1'b1, 2'd3, 1'b0, 9'h000, '0, 1'b0);
    wait_txn(10, lat, wc, ms, dc);
    n_vec++;
    if (ms !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_size_mfa: mfa_seen=%b expected 0", ms);
    end
  endtask

  task automatic test_timeout;
    int lat, wc, dc;
    bit ms;
    moc_en = 1'b0;
    issue(1'b1, 2'd2, 1'b0, 9'h020, '0, 1'b1);
    wait_txn(TO + 20, lat, wc, ms, dc);
    n_vec++;
    if (wc !== TO) begin
      n_bad++;
      $display("FAIL timeout_len: got %0d WAIT cycles expected %0d", wc, TO);
    end
  endtask

  task automatic test_reset_mid;
    int lat, wc, dc;
    bit ms;
    moc_en = 1'b0;
    mem_rdata = 32'hCAFEF00D;
    issue(1'b0, 2'd2, 1'b0, 9'h0FC, 32'h55AA55AA, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy, done, done_err, err, rdata, mfa, mem_rw, mem_addr, mem_wdata, mem_mode} !==
        {1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 9'h0, 32'h0, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_mid: busy=%b done=%b derr=%b err=%0d rdata=%h mfa=%b rw=%b addr=%h wdata=%h mode=%0d",
               busy, done, done_err, err, rdata, mfa, mem_rw, mem_addr, mem_wdata, mem_mode);
    end
    reset = 1'b0;
    sb.delete();
    last_rd = '0;
    moc_en = 1'b1; moc_delay = 0;
    issue(1'b1, 2'd2, 1'b0, 9'h0FC, '0, 1'b0);
    wait_txn(10, lat, wc, ms, dc);
    n_vec++;
    if (lat !== 3) begin
      n_bad++;
      $display("FAIL post_reset_latency: got %0d expected 3", lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat, wc, d1, d2, d3;
    bit ms;
    moc_en = 1'b1; moc_delay = 0;
    mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    for (int i = 0; i < 3; i++) predict(1'b1, 2'd2, 1'b0, 9'h040, 1'b0);
    req = 1'b1; rw = 1'b1; size = 2'd2; sign_ext = 1'b0; addr = 9'h040;
    @(negedge clk);
    wait_txn(10, lat, wc, ms, d1);
    wait_txn(10, lat, wc, ms, d2);
    wait_txn(10, lat, wc, ms, d3);
    req = 1'b0;
    n_vec++;
    if (d2 - d1 !== 4 || d3 - d2 !== 4) begin
      n_bad++;
      $display("FAIL b2b_period: gaps %0d/%0d expected 4/4", d2 - d1, d3 - d2);
    end
  endtask

  task automatic test_moc_held;
    int lat, wc, dc;
    bit ms;
    moc_en = 1'b1; moc_delay = 0;
    mem_rdata = 32'h00000011;
    @(negedge clk);
    predict(1'b1, 2'd0, 1'b0, 9'h030, 1'b0);
    req = 1'b1; rw = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 9'h030;
    @(negedge clk);
    @(negedge clk);
    moc_force = 1'b1; moc_en = 1'b0;
    wait_txn(5, lat, wc, ms, dc);
    mem_rdata = 32'h00000022;
    predict(1'b1, 2'd0, 1'b0, 9'h030, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (mfa !== 1'b1 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL moc_held%0d: mfa=%b done=%b expected 1/0", i, mfa, done);
      end
    end
    moc_force = 1'b0;
    @(negedge clk);
    moc_force = 1'b1;
    wait_txn(5, lat, wc, ms, dc);
    req = 1'b0;
    moc_force = 1'b0;
  endtask

  initial begin
    last_rd = '0;
    test_reset();
    test_word_store();
    test_loads();
    test_request_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_moc_held();
    repeat (2) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
